cla_queue_mc: RTL and testbench

- Multi-channel clause queue; successor to the single-channel clause FIFO. Width, depth and channel count are parameters.
- NCH independent FIFOs are pushed in parallel by upstream clause producers.
- A round-robin arbiter drains them onto one valid/ready output stream toward the inference engine.
- Adds per-channel occupancy, almost-full, sticky overflow and a stall-stable output; none of these existed before.

---
 rtl/cla_queue_mc.sv | 146 ++++++++++++++
 tb/tb_cla_queue_mc.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_queue_mc.sv
// Multi-channel clause queue: NCH parallel-push FIFOs drained round-robin onto one valid/ready stream.
// Latency: a word pushed at edge t is visible on out_* after edge t; one pop per cycle.
// Backpressure: out_ready low locks the selected channel/word until taken; pushes to a full channel drop and set overflow.
// Optional CLA_QUEUE_DROP_CNT_EN adds saturating per-channel drop counters (drop_cnt).
module cla_queue_mc #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 16,
    parameter int NCH      = 4,
    parameter int AF_LEVEL = DEPTH - 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NCH-1:0]                      push,
    input  logic [NCH*WIDTH-1:0]                push_data,
    output logic [NCH-1:0]                      full,
    output logic [NCH-1:0]                      almost_full,
    output logic [NCH*($clog2(DEPTH)+1)-1:0]    count,
    output logic [NCH-1:0]                      overflow,
    input  logic [NCH-1:0]                      clr_overflow,
    output logic                                out_valid,
    output logic [WIDTH-1:0]                    out_data,
    output logic [$clog2(NCH)-1:0]              out_ch,
    input  logic                                out_ready
`ifdef CLA_QUEUE_DROP_CNT_EN
    ,
    output logic [NCH*16-1:0]                   drop_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(NCH);

    logic [WIDTH-1:0] mem  [NCH][DEPTH];
    logic [PW-1:0]    head [NCH];
    logic [PW-1:0]    tail [NCH];
    logic [PW-1:0]    cnt  [NCH];

    logic [NCH-1:0] empty;
    logic [NCH-1:0] wr_en;
    logic [NCH-1:0] drop;
    logic [NCH-1:0] pop_ch;
    logic [CW-1:0]  rr_ptr;
    logic [CW-1:0]  sel_q;
    logic [CW-1:0]  rr_sel;
    logic [CW-1:0]  sel;
    logic [CW-1:0]  idx;
    logic           found;
    logic           lock_q;
    logic           pop;

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            cnt[c]                = tail[c] - head[c];
            empty[c]              = (head[c] == tail[c]);
            full[c]               = (head[c][AW-1:0] == tail[c][AW-1:0]) && (head[c][AW] != tail[c][AW]);
            almost_full[c]        = (cnt[c] >= PW'(AF_LEVEL));
            count[c*PW +: PW]     = cnt[c];
        end
    end

    // Round-robin scan starting at rr_ptr; a stalled selection is frozen in sel_q.
    always_comb begin
        rr_sel = rr_ptr;
        found  = 1'b0;
        idx    = '0;
        for (int i = 0; i < NCH; i++) begin
            idx = CW'((int'(rr_ptr) + i) % NCH);
            if (!found && !empty[idx]) begin
                found  = 1'b1;
                rr_sel = idx;
            end
        end
        sel       = lock_q ? sel_q : rr_sel;
        out_valid = ~&empty;
        pop       = out_valid && out_ready;
        out_ch    = sel;
        out_data  = out_valid ? mem[sel][head[sel][AW-1:0]] : '0;
        for (int c = 0; c < NCH; c++) begin
            pop_ch[c] = pop && (sel == CW'(c));
            // A full channel still accepts when its head leaves in the same cycle.
            wr_en[c]  = push[c] && (!full[c] || pop_ch[c]);
            drop[c]   = push[c] && full[c] && !pop_ch[c];
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (wr_en[c]) begin
                mem[c][tail[c][AW-1:0]] <= push_data[c*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                head[c] <= '0;
                tail[c] <= '0;
            end
            overflow <= '0;
            rr_ptr   <= '0;
            sel_q    <= '0;
            lock_q   <= 1'b0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (wr_en[c]) begin
                    tail[c] <= tail[c] + 1'b1;
                end
                if (pop_ch[c]) begin
                    head[c] <= head[c] + 1'b1;
                end
                if (drop[c]) begin
                    overflow[c] <= 1'b1;
                end else if (clr_overflow[c]) begin
                    overflow[c] <= 1'b0;
                end
            end
            if (pop) begin
                rr_ptr <= (sel == CW'(NCH - 1)) ? '0 : sel + 1'b1;
                lock_q <= 1'b0;
            end else if (out_valid) begin
                lock_q <= 1'b1;
                sel_q  <= sel;
            end
        end
    end

`ifdef CLA_QUEUE_DROP_CNT_EN
    // A clear coinciding with a drop leaves that drop counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (clr_overflow[c]) begin
                    drop_cnt[c*16 +: 16] <= drop[c] ? 16'd1 : 16'd0;
                end else if (drop[c] && (drop_cnt[c*16 +: 16] != 16'hFFFF)) begin
                    drop_cnt[c*16 +: 16] <= drop_cnt[c*16 +: 16] + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_cla_queue_mc.sv
// Bench for cla_queue_mc (NCH=4, DEPTH=4, WIDTH=8, AF_LEVEL=2): queue-based reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_cla_queue_mc;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int N  = 4;
    localparam int AF = 2;
    localparam int PW = 3;
    localparam int CW = 2;

    logic              clk;
    logic              rst_n;
    logic [N-1:0]      push;
    logic [N*W-1:0]    push_data;
    logic [N-1:0]      full;
    logic [N-1:0]      almost_full;
    logic [N*PW-1:0]   count;
    logic [N-1:0]      overflow;
    logic [N-1:0]      clr_overflow;
    logic              out_valid;
    logic [W-1:0]      out_data;
    logic [CW-1:0]     out_ch;
    logic              out_ready;
`ifdef CLA_QUEUE_DROP_CNT_EN
    logic [N*16-1:0]   drop_cnt;
`endif

    int n_chk = 0;
    int n_err = 0;

    cla_queue_mc #(.WIDTH(W), .DEPTH(D), .NCH(N), .AF_LEVEL(AF)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .push         (push),
        .push_data    (push_data),
        .full         (full),
        .almost_full  (almost_full),
        .count        (count),
        .overflow     (overflow),
        .clr_overflow (clr_overflow),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ch       (out_ch),
        .out_ready    (out_ready)
`ifdef CLA_QUEUE_DROP_CNT_EN
        ,
        .drop_cnt     (drop_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one queue per channel plus arbitration state.
    logic [W-1:0] q [N][$];
    logic [N-1:0] m_ov = '0;
    int           m_rr = 0;
    int           m_selq = 0;
    bit           m_lock = 1'b0;
`ifdef CLA_QUEUE_DROP_CNT_EN
    int           m_drop [N];
`endif

    function automatic int m_sel_f();
        if (m_lock) return m_selq;
        for (int i = 0; i < N; i++) begin
            int k;
            k = (m_rr + i) % N;
            if (q[k].size() != 0) return k;
        end
        return m_rr;
    endfunction

    initial begin : model
        int s;
        bit v;
        bit dr;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int c = 0; c < N; c++) begin
                    q[c].delete();
`ifdef CLA_QUEUE_DROP_CNT_EN
                    m_drop[c] = 0;
`endif
                end
                m_ov   = '0;
                m_rr   = 0;
                m_selq = 0;
                m_lock = 1'b0;
            end else begin
                v = 1'b0;
                for (int c = 0; c < N; c++) if (q[c].size() != 0) v = 1'b1;
                s = m_sel_f();
                if (v && out_ready) begin
                    void'(q[s].pop_front());
                    m_rr   = (s + 1) % N;
                    m_lock = 1'b0;
                end else if (v) begin
                    m_lock = 1'b1;
                    m_selq = s;
                end
                for (int c = 0; c < N; c++) begin
                    dr = 1'b0;
                    if (push[c]) begin
                        if (q[c].size() < D) q[c].push_back(push_data[c*W +: W]);
                        else dr = 1'b1;
                    end
                    if (dr) m_ov[c] = 1'b1;
                    else if (clr_overflow[c]) m_ov[c] = 1'b0;
`ifdef CLA_QUEUE_DROP_CNT_EN
                    if (clr_overflow[c]) m_drop[c] = dr ? 1 : 0;
                    else if (dr && m_drop[c] < 65535) m_drop[c] = m_drop[c] + 1;
`endif
                end
            end
        end
    end

    initial begin : compare
        logic [N-1:0]    ef;
        logic [N-1:0]    eaf;
        logic [N*PW-1:0] ecnt;
        bit              ev;
        int              s;
        forever begin
            @(negedge clk);
            ev = 1'b0;
            for (int c = 0; c < N; c++) begin
                ecnt[c*PW +: PW] = PW'(q[c].size());
                ef[c]  = (q[c].size() == D);
                eaf[c] = (q[c].size() >= AF);
                if (q[c].size() != 0) ev = 1'b1;
            end
            chk("m_valid", out_valid, ev);
            chk("m_count", count, ecnt);
            chk("m_full", full, ef);
            chk("m_afull", almost_full, eaf);
            chk("m_ovf", overflow, m_ov);
            if (ev) begin
                s = m_sel_f();
                chk("m_ch", out_ch, s);
                chk("m_data", out_data, q[s][0]);
            end else begin
                chk("m_data_idle", out_data, 0);
            end
`ifdef CLA_QUEUE_DROP_CNT_EN
            for (int c = 0; c < N; c++) chk("m_drop", drop_cnt[c*16 +: 16], m_drop[c]);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input int c, input logic [W-1:0] d);
        push_data[c*W +: W] = d;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    logic [CW-1:0] seq_ch [6] = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
    logic [W-1:0]  seq_d  [6] = '{8'h00, 8'h10, 8'h30, 8'h01, 8'h11, 8'h31};
    logic [W-1:0]  t5_d   [4] = '{8'h51, 8'h52, 8'h53, 8'h77};

    initial begin : stim
        rst_n        = 1'b0;
        push         = '0;
        push_data    = '0;
        clr_overflow = '0;
        out_ready    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_full", full, 0);
        chk("rst_afull", almost_full, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_ch", out_ch, 0);
        chk("rst_data", out_data, 0);
        rst_n = 1'b1;
        step();

        // Single word on ch2, held under stall.
        push = 4'b0100; set_d(2, 8'hA5);
        step();
        push = '0;
        chk("t1_valid", out_valid, 1);
        chk("t1_ch", out_ch, 2);
        chk("t1_data", out_data, 8'hA5);
        chk("t1_cnt", count[2*PW +: PW], 1);
        repeat (3) begin
            step();
            chk("t1_hold_ch", out_ch, 2);
            chk("t1_hold_data", out_data, 8'hA5);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t1_empty", out_valid, 0);
        chk("t1_cnt0", count[2*PW +: PW], 0);

        // Fill ch0, overflow, clear, drain.
        push = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            set_d(0, 8'(8'h10 + i));
            step();
            chk("t2_afull", almost_full[0], (i + 1) >= AF);
            chk("t2_full", full[0], i == 3);
        end
        set_d(0, 8'h14);
        step();
        push = '0;
        chk("t2_ovf_set", overflow[0], 1);
        chk("t2_cnt4", count[0 +: PW], 4);
`ifdef CLA_QUEUE_DROP_CNT_EN
        chk("t2_drop1", drop_cnt[15:0], 1);
`endif
        step(); step();
        chk("t2_ovf_sticky", overflow[0], 1);
        clr_overflow = 4'b0001;
        step();
        clr_overflow = '0;
        chk("t2_ovf_clr", overflow[0], 0);
`ifdef CLA_QUEUE_DROP_CNT_EN
        chk("t2_drop_clr", drop_cnt[15:0], 0);
`endif
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t2_drain", out_data, 8'(8'h10 + i));
            step();
        end
        out_ready = 1'b0;
        chk("t2_empty", out_valid, 0);

        // Round-robin across ch0, ch1, ch3.
        do_reset();
        push = 4'b1011;
        set_d(0, 8'h00); set_d(1, 8'h10); set_d(3, 8'h30);
        step();
        set_d(0, 8'h01); set_d(1, 8'h11); set_d(3, 8'h31);
        step();
        push = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("t3_ch", out_ch, seq_ch[i]);
            chk("t3_data", out_data, seq_d[i]);
            step();
        end
        out_ready = 1'b0;
        chk("t3_empty", out_valid, 0);

        // Stall lock on ch1 while ch0 (higher rr priority) fills.
        push = 4'b0010; set_d(1, 8'h41);
        step();
        push = '0;
        chk("t4_sel1", out_ch, 1);
        step();
        push = 4'b0001; set_d(0, 8'h42);
        step();
        push = '0;
        chk("t4_lock_ch", out_ch, 1);
        chk("t4_lock_data", out_data, 8'h41);
        chk("t4_cnt0", count[0 +: PW], 1);
        step();
        chk("t4_lock_ch2", out_ch, 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t4_next_ch", out_ch, 0);
        chk("t4_next_data", out_data, 8'h42);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t4_empty", out_valid, 0);

        // Push into a full ch0 while its head is popped.
        push = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            set_d(0, 8'(8'h50 + i));
            step();
        end
        chk("t5_full", full[0], 1);
        chk("t5_head", out_data, 8'h50);
        set_d(0, 8'h77);
        out_ready = 1'b1;
        step();
        push = '0;
        chk("t5_no_ovf", overflow[0], 0);
        chk("t5_cnt", count[0 +: PW], 4);
        for (int i = 0; i < 4; i++) begin
            chk("t5_order", out_data, t5_d[i]);
            step();
        end
        out_ready = 1'b0;
        chk("t5_empty", out_valid, 0);

        // Asynchronous reset mid-stream.
        push = 4'b1111;
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < N; c++) set_d(c, 8'(c * 16 + i));
            step();
        end
        push = 4'b0010;
        repeat (3) step();
        push = '0;
        chk("t6_pre_valid", out_valid, 1);
        chk("t6_pre_ovf", overflow[1], 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_valid", out_valid, 0);
        chk("t6_count", count, 0);
        chk("t6_ovf", overflow, 0);
        chk("t6_full", full, 0);
`ifdef CLA_QUEUE_DROP_CNT_EN
        chk("t6_drop", drop_cnt, 0);
`endif
        step();
        rst_n = 1'b1;
        step();
        chk("t6_after", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
